// File: rtl/accum_pkg.sv
// accum_pkg: shared FSM state type and saturation limits for accum_stream
//   state_e      : IDLE / ACC / DONE frame states
//   sat_max(w)   : bit pattern of the largest signed w-bit value
//   sat_min(w)   : bit pattern of the smallest signed w-bit value
package accum_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/accum_adder.sv
// accum_adder: combinational WIDTH-bit adder with carry-out and signed overflow
//   a_i, b_i : operands (two's complement)
//   sum_o    : a_i + b_i modulo 2^WIDTH
//   carry_o  : unsigned carry-out of the raw addition
//   ovf_o    : signed overflow (same-sign operands, result sign differs)
module accum_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
endmodule

// File: rtl/accum_stream.sv
// accum_stream: sums a frame of i_len streamed samples and hands the result downstream
//   i_clk / ni_rst        : clock, synchronous active-low reset
//   i_start, i_len        : frame start pulse and sample count (sampled in IDLE only)
//   i_clr                 : synchronous abort, returns to IDLE with cleared state
//   i_valid, i_data       : sample stream, accepted while o_ready (ACC state)
//   o_valid, i_ready      : result handshake, result held until i_ready in DONE
//   o_sum, o_carry, o_ovf : frame sum, sticky unsigned carry, sticky signed overflow
//   o_busy                : FSM not in IDLE
//   Macro ACCUM_SAT_EN    : clamp the sum on signed overflow instead of wrapping
module accum_stream
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_busy
);
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, add_sum, new_sum;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, add_carry, add_ovf;
  accum_adder #(.WIDTH(WIDTH)) u_add (
    .a_i    (acc_q),
    .b_i    (i_data),
    .sum_o  (add_sum),
    .carry_o(add_carry),
    .ovf_o  (add_ovf)
  );
`ifdef ACCUM_SAT_EN
  // Overflow direction follows the accumulator sign: both operands share it.
  assign new_sum = add_ovf ? (acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX) : add_sum;
`else
  assign new_sum = add_sum;
`endif
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (i_start) begin
        acc_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = i_len;
        state_d = (i_len != '0) ? ACC : DONE;
      end
      ACC: if (i_valid) begin
        acc_d   = new_sum;
        carry_d = carry_q | add_carry;
        ovf_d   = ovf_q | add_ovf;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == LEN_W'(1)) ? DONE : ACC;
      end
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
  assign o_ready = (state_q == ACC);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_sum   = acc_q;
  assign o_carry = carry_q;
  assign o_ovf   = ovf_q;
endmodule

// File: tb/tb_accum_stream.sv
// tb_accum_stream: randomized and directed frames checked through a result scoreboard
module tb_accum_stream;
  localparam int W = 8;
  localparam int LW = 4;
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_clr = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic [W-1:0] i_data = '0;
  logic o_ready, o_valid, o_carry, o_ovf, o_busy;
  logic [W-1:0] o_sum;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           n;
  } exp_t;
  exp_t sb[$];
  accum_stream #(.WIDTH(W), .LEN_W(LW)) dut (
    .i_clk(clk), .ni_rst(rst_n), .i_start(i_start), .i_len(i_len), .i_clr(i_clr),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry), .o_ovf(o_ovf), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  // Reference: the running sum is kept as a signed integer in range; carry/overflow
  // are decided from plain unsigned/signed arithmetic on each sample.
  function automatic exp_t model(input int len, input logic [W-1:0] d[$]);
    exp_t e;
    int acc = 0;
    e.carry = 1'b0;
    e.ovf = 1'b0;
    e.n = len;
    for (int k = 0; k < len; k++) begin
      int s = acc + $signed(d[k]);
      int u = (acc & 255) + int'(d[k]);
      if (u > 255) e.carry = 1'b1;
      if (s > 127 || s < -128) begin
        e.ovf = 1'b1;
`ifdef ACCUM_SAT_EN
        acc = (s > 127) ? 127 : -128;
`else
        acc = (s > 127) ? s - 256 : s + 256;
`endif
      end else acc = s;
    end
    e.sum = W'(acc);
    return e;
  endfunction
  // Monitor: pops on each rising o_valid, then checks the result stays put.
  logic pv = 1'b0;
  exp_t cur = '{sum: '0, carry: 1'b0, ovf: 1'b0, n: 0};
  int accepts = 0, last_evt = -10;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      accepts = 0;
    end else begin
      if (o_valid && !pv) begin
        if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          cur = sb.pop_front();
          chk("sum", o_sum, cur.sum);
          chk("carry", o_carry, cur.carry);
          chk("ovf", o_ovf, cur.ovf);
          chk("accepts", accepts, cur.n);
          chk("latency", cyc - last_evt, 32'd1);
        end
      end else if (o_valid) chk("hold", {o_sum, o_carry, o_ovf}, {cur.sum, cur.carry, cur.ovf});
      if (!o_busy) accepts = 0;
      if (i_valid && o_ready) begin
        accepts++;
        last_evt = cyc;
      end
      if (!o_busy && i_start && !i_clr) last_evt = cyc;
      pv = o_valid;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input int len, input logic [W-1:0] d[$], input int gap_pct, input int rdy_wait);
    exp_t e = model(len, d);
    int t;
    sb.push_back(e);
    i_start = 1'b1;
    i_len = LW'(len);
    tick;
    i_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        i_valid = 1'b0;
        i_data = W'($urandom);
        tick;
      end
      i_valid = 1'b1;
      i_data = d[k];
      tick;
    end
    i_valid = 1'b0;
    t = 0;
    while (!o_valid && t < 40) begin
      tick;
      t++;
    end
    if (!o_valid) chk("valid_timeout", 32'd0, 32'd1);
    for (int k = 0; k < rdy_wait; k++) begin
      i_start = 1'($urandom);
      i_len = LW'($urandom);
      i_valid = 1'($urandom);
      i_data = W'($urandom);
      tick;
    end
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    chk("idle_after", {o_valid, o_busy, o_ready}, 32'd0);
    chk("idle_keep", {o_sum, o_carry, o_ovf}, {e.sum, e.carry, e.ovf});
  endtask
  task automatic abort_frame(input bit use_rst, input logic [W-1:0] a, input logic [W-1:0] b);
    i_start = 1'b1;
    i_len = LW'(5);
    tick;
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data = a;
    tick;
    i_data = b;
    tick;
    if (use_rst) rst_n = 1'b0;
    else i_clr = 1'b1;
    i_data = 8'h55;
    i_start = 1'b1;
    tick;
    rst_n = 1'b1;
    i_clr = 1'b0;
    i_valid = 1'b0;
    i_start = 1'b0;
    chk(use_rst ? "rst_abort_ctl" : "clr_abort_ctl", {o_busy, o_valid, o_ready}, 32'd0);
    chk(use_rst ? "rst_abort_res" : "clr_abort_res", {o_sum, o_carry, o_ovf}, 32'd0);
  endtask
  initial begin
    logic [W-1:0] q[$];
    tick;
    tick;
    chk("reset_ctl", {o_busy, o_valid, o_ready}, 32'd0);
    chk("reset_res", {o_sum, o_carry, o_ovf}, 32'd0);
    rst_n = 1'b1;
    tick;
    q = {};
    q.push_back(8'd10); q.push_back(8'd20); q.push_back(8'd30);
    run_frame(3, q, 0, 0);
    q = {};
    q.push_back(8'd100); q.push_back(8'd50);
    run_frame(2, q, 0, 1);
    q = {};
    q.push_back(8'hFF); q.push_back(8'h01);
    run_frame(2, q, 0, 0);
    q = {};
    q.push_back(8'h80); q.push_back(8'h80);
    run_frame(2, q, 0, 0);
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(W'($urandom));
    run_frame(4, q, 50, 5);
    q = {};
    run_frame(0, q, 0, 2);
    abort_frame(1'b1, 8'd100, 8'd50);
    q = {};
    q.push_back(8'd7); q.push_back(8'd8); q.push_back(8'hFE);
    run_frame(3, q, 0, 0);
    abort_frame(1'b0, 8'hFF, 8'h02);
    q = {};
    q.push_back(8'd1); q.push_back(8'd2); q.push_back(8'd3); q.push_back(8'd4); q.push_back(8'd5);
    run_frame(5, q, 20, 1);
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(15);
      q = {};
      for (int k = 0; k < len; k++) q.push_back(W'($urandom));
      run_frame(len, q, 30, $urandom_range(3));
    end
    tick;
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_stream.md
ACCUM_STREAM -- requirements
Module: accum_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data and accumulator width in bits, minimum 2.
REQ-002 The block SHALL have parameter LEN_W, default 4: width of the frame-length field.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port ni_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit: frame start pulse, sampled only in IDLE.
REQ-006 The block SHALL have port i_len, input, LEN_W bits: samples per frame, captured with i_start.
REQ-007 The block SHALL have port i_clr, input, 1 bit: synchronous abort/clear.
REQ-008 The block SHALL have port i_valid, input, 1 bit: upstream sample valid.
REQ-009 The block SHALL have port i_data, input, WIDTH bits: two's-complement sample.
REQ-010 The block SHALL have port o_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-011 The block SHALL have port o_valid, output, 1 bit: frame result valid.
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port o_sum, output, WIDTH bits: frame sum.
REQ-014 The block SHALL have port o_carry, output, 1 bit: sticky unsigned carry-out seen in the frame.
REQ-015 The block SHALL have port o_ovf, output, 1 bit: sticky signed overflow seen in the frame.
REQ-016 The block SHALL have port o_busy, output, 1 bit: state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACC, DONE.
REQ-018 In IDLE, i_start=1 with i_len!=0 SHALL, at the next edge, clear the accumulator and flags, load the remaining count with i_len, and enter ACC.
REQ-019 In IDLE, i_start=1 with i_len==0 SHALL clear the accumulator and flags and enter DONE directly, giving o_sum=0.
REQ-020 o_ready SHALL be 1 only in ACC; a sample is accepted on an edge where i_valid&&o_ready.
REQ-021 Each accepted sample SHALL set acc <= acc + i_data (WIDTH bits); o_carry |= unsigned carry-out; o_ovf |= signed overflow (both operands same sign, result sign differs).
REQ-022 Each accepted sample SHALL decrement the remaining count; accepting the sample at count==1 SHALL enter DONE, so o_valid rises exactly 1 cycle after the last accept.
REQ-023 In DONE, o_valid SHALL be 1, and o_sum, o_carry and o_ovf SHALL be held stable until i_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-024 In IDLE, o_sum, o_carry and o_ovf SHALL retain the last frame's values.
REQ-025 i_start outside IDLE SHALL be ignored.
REQ-026 i_valid outside ACC SHALL be ignored.
REQ-027 i_clr=1 SHALL override all else except reset: at the next edge go to IDLE, and set accumulator, count, o_carry and o_ovf to 0.

Reset
REQ-028 ni_rst=0 at an edge SHALL set state to IDLE and the accumulator and count to 0, and drive o_sum=0, o_carry=0, o_ovf=0, o_valid=0, o_ready=0, o_busy=0, regardless of state, including mid-frame.

Configuration
REQ-029 With macro ACCUM_SAT_EN defined, a sample causing signed overflow SHALL clamp the accumulator to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow), and o_ovf SHALL still be set.
REQ-030 Without ACCUM_SAT_EN, the sum SHALL wrap modulo 2^WIDTH.
REQ-031 o_carry SHALL reflect the raw adder carry-out in both configurations.

Structure
REQ-032 A shared package accum_pkg SHALL hold the state enum typedef (IDLE/ACC/DONE) and the saturation constant functions.
REQ-033 The block SHALL contain one sub-module, accum_adder #(WIDTH), a combinational adder with sum, carry and signed-overflow outputs.

Verification (WIDTH=8, LEN_W=4)
REQ-034 The bench SHALL cover: len=3, samples 10,20,30 -> o_sum=60, o_carry=0, o_ovf=0, o_valid 1 cycle after the 3rd accept.
REQ-035 The bench SHALL cover: len=2, samples 100,50 -> without ACCUM_SAT_EN o_sum=0x96 and o_ovf=1; with it o_sum=0x7F and o_ovf=1.
REQ-036 The bench SHALL cover: len=2, samples 0xFF,0x01 -> o_sum=0x00, o_carry=1, o_ovf=0.
REQ-037 The bench SHALL cover: len=4 with i_valid gaps, then i_ready held 0 for 5 cycles -> exactly 4 accepts, and o_valid/o_sum stable until i_ready=1, then IDLE.
REQ-038 The bench SHALL cover: i_start with i_len=0 -> o_valid=1, o_sum=0 on the next cycle.
REQ-039 The bench SHALL cover: ni_rst=0 (or i_clr=1) after 2 of 5 samples -> next edge IDLE, o_sum=0, flags 0; a new frame then sums correctly.
